// File: rtl/pipe_field_scroller_pkg.sv
// Shared types and default geometry for the pipe playfield, LFSR gap source
// and LED-matrix driver.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } game_state_t;

  localparam int unsigned DEF_ROWS  = 16;
  localparam int unsigned DEF_COLS  = 16;
  localparam int unsigned DEF_GAP_H = 3;

endpackage

// File: rtl/pipe_field_scroller_if.sv
// Game-control, gap-source and display signals of the pipe field scroller.
interface pipe_field_scroller_if
  import pipe_pkg::*;
#(
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned COLS      = DEF_COLS,
  parameter int unsigned SPACING_W = 5,
  parameter int unsigned SCORE_W   = 8
);
  localparam int unsigned RW = $clog2(ROWS);

  logic                       start;
  logic                       scroll_tick;
  logic [SPACING_W-1:0]       spacing;
  logic                       gap_valid;
  logic [RW-1:0]              gap_pos;
  logic                       gap_ack;
  logic [RW-1:0]              bird_row;
  logic [ROWS-1:0][COLS-1:0]  RedPixels;
  logic                       pipe_passed;
  logic [SCORE_W-1:0]         score;
  logic                       collision;
  logic [1:0]                 state;

  modport master (
    output start, scroll_tick, spacing, gap_valid, gap_pos, bird_row,
    input  gap_ack, RedPixels, pipe_passed, score, collision, state
  );

  modport slave (
    input  start, scroll_tick, spacing, gap_valid, gap_pos, bird_row,
    output gap_ack, RedPixels, pipe_passed, score, collision, state
  );
endinterface

// File: rtl/pipe_field_scroller_column_gen.sv
// Builds one pipe column: all rows set except a GAP_H-row gap starting at
// gap_pos, clamped so the gap never runs off the bottom row.
module pipe_column_gen
  import pipe_pkg::*;
#(
  parameter int unsigned ROWS  = DEF_ROWS,
  parameter int unsigned GAP_H = DEF_GAP_H
) (
  input  logic [$clog2(ROWS)-1:0] gap_pos,
  output logic [ROWS-1:0]         column
);
  localparam int unsigned GMAX = ROWS - GAP_H;

  int unsigned g;

  always_comb begin
    g      = (32'(gap_pos) > GMAX) ? GMAX : 32'(gap_pos);
    column = '1;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (r >= g && r < g + GAP_H) column[r] = 1'b0;
    end
  end
endmodule

// File: rtl/pipe_field_scroller.sv
// Scrolling obstacle bitmap with pipe launch, pass scoring, bird collision
// and IDLE/RUN/FROZEN game control.
module pipe_field_scroller
  import pipe_pkg::*;
#(
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned COLS      = DEF_COLS,
  parameter int unsigned GAP_H     = DEF_GAP_H,
  parameter int unsigned BIRD_COL  = 12,
  parameter int unsigned SPACING_W = 5,
  parameter int unsigned SCORE_W   = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  pipe_field_scroller_if.slave  bus
);
  game_state_t               state_q, state_n;
  logic [ROWS-1:0][COLS-1:0] pix_q;
  logic [COLS-1:0]           tag_q;
  logic [SPACING_W-1:0]      cnt_q;
  logic [SCORE_W-1:0]        score_q;
  logic                      ack_q, passed_q, coll_q;
  logic [ROWS-1:0]           new_col;
  logic                      hit, advance, launch;
  logic [SPACING_W:0]        eff_m1;

  pipe_column_gen #(.ROWS(ROWS), .GAP_H(GAP_H)) u_col (
    .gap_pos (bus.gap_pos),
    .column  (new_col)
  );

  always_comb begin
    hit = 1'b0;
    if (state_q == RUN && 32'(bus.bird_row) < ROWS) hit = pix_q[bus.bird_row][BIRD_COL];
  end

  // start outranks collision, which outranks the scroll tick
  always_comb begin
    state_n = state_q;
    if (bus.start)  state_n = RUN;
    else if (hit)   state_n = FROZEN;
  end

  always_comb begin
    advance = (state_q == RUN) && bus.scroll_tick && !bus.start && !hit;
    launch  = advance && (cnt_q == '0) && bus.gap_valid;
    eff_m1  = (bus.spacing < SPACING_W'(2)) ? (SPACING_W+1)'(1)
                                            : ({1'b0, bus.spacing} - 1'b1);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pix_q    <= '0;
      tag_q    <= '0;
      cnt_q    <= '0;
      score_q  <= '0;
      ack_q    <= 1'b0;
      passed_q <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      ack_q    <= 1'b0;
      passed_q <= 1'b0;
      if (bus.start) begin
        pix_q   <= '0;
        tag_q   <= '0;
        cnt_q   <= '0;
        score_q <= '0;
        coll_q  <= 1'b0;
      end else if (hit) begin
        coll_q <= 1'b1;
      end else if (advance) begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          pix_q[r] <= {pix_q[r][COLS-2:0], launch & new_col[r]};
        end
        tag_q <= {tag_q[COLS-2:0], launch};
        ack_q <= launch;
        cnt_q <= ({1'b0, cnt_q} >= eff_m1) ? '0 : cnt_q + 1'b1;
        if (tag_q[BIRD_COL]) begin
          passed_q <= 1'b1;
          if (score_q != '1) score_q <= score_q + 1'b1;
        end
      end
    end
  end

  assign bus.RedPixels   = pix_q;
  assign bus.gap_ack     = ack_q;
  assign bus.pipe_passed = passed_q;
  assign bus.score       = score_q;
  assign bus.collision   = coll_q;
  assign bus.state       = state_q;

endmodule
